// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Optional build macro: MULTICYCLE_BNE_EN makes bne a supported opcode.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef MULTICYCLE_BNE_EN
            OP_BNE: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop and R-type funct to the 3-bit ALU control code.
module mc_aludec
    import mips_mc_pkg::*;
#(
    parameter int FNW = 6
) (
    input  aluop_t           aluop,
    input  logic [FNW-1:0]   funct,
    output logic [2:0]       alucontrol
);

    // Unknown funct values fall back to add so the instruction still retires.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS core (fetch/decode/execute/mem/wb).
// Optional build macro: MULTICYCLE_BNE_EN adds bne through the BEQ state.
module multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    output logic           iord,
    output logic           memwrite,
    output logic           irwrite,
    output logic           regdst,
    output logic           memtoreg,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [2:0]     alucontrol,
    output logic [1:0]     pcsrc,
    output logic           pcen,
    output logic           illegal_op
);

    state_t state_r;
    state_t cur_s;
    aluop_t aluop_s;
    logic   memwrite_s, irwrite_s, regwrite_s, pcwrite_s, branch_s, take_s;
`ifdef MULTICYCLE_BNE_EN
    logic   branch_ne_r;
`endif

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:  state_r <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_r <= S_MEMADR;
                        OP_RTYPE:     state_r <= S_EXECUTE;
                        OP_BEQ:       state_r <= S_BEQ;
                        OP_ADDI:      state_r <= S_ADDIEX;
                        OP_J:         state_r <= S_JUMP;
`ifdef MULTICYCLE_BNE_EN
                        OP_BNE:       state_r <= S_BEQ;
`endif
                        default:      state_r <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state_r <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   state_r <= S_MEMWB;
                S_EXECUTE: state_r <= S_ALUWB;
                S_ADDIEX:  state_r <= S_ADDIWB;
                default:   state_r <= S_FETCH;
            endcase
        end
    end

`ifdef MULTICYCLE_BNE_EN
    // Remember whether the branch in flight is bne; captured once in DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_ne_r <= 1'b0;
        end else if (state_r == S_DECODE) begin
            branch_ne_r <= (op == OP_BNE);
        end else begin
            branch_ne_r <= branch_ne_r;
        end
    end
`endif

    // While reset is high the outputs decode as FETCH; strobes are masked below.
    assign cur_s = reset ? S_FETCH : state_r;

    // Per-state datapath controls.
    always_comb begin
        iord       = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop_s    = ALUOP_ADD;
        pcsrc      = 2'b00;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        case (cur_s)
            S_FETCH: begin
                irwrite_s = 1'b1;
                alusrcb   = 2'b01;
                pcwrite_s = 1'b1;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop_s = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BEQ: begin
                alusrca  = 1'b1;
                aluop_s  = ALUOP_SUB;
                pcsrc    = 2'b01;
                branch_s = 1'b1;
            end
            S_ADDIWB: regwrite_s = 1'b1;
            S_JUMP: begin
                pcsrc     = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: iord = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_BNE_EN
    assign take_s = branch_s & (branch_ne_r ? ~zero : zero);
`else
    assign take_s = branch_s & zero;
`endif

    assign memwrite   = memwrite_s & ~reset;
    assign irwrite    = irwrite_s  & ~reset;
    assign regwrite   = regwrite_s & ~reset;
    assign pcen       = (pcwrite_s | take_s) & ~reset;
    assign illegal_op = (cur_s == S_DECODE) & ~op_supported(op) & ~reset;

    mc_aludec #(.FNW(FNW)) u_aludec (
        .aluop      (aluop_s),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected controls queued, then compared.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       pcen, illegal_op;
    logic [15:0] obs;

`ifdef MULTICYCLE_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    typedef enum {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_EX, T_AWB, T_BQ, T_AIE, T_AIW, T_JP} tst_e;
    typedef struct {
        logic [15:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    localparam logic [15:0] V_RESET = {7'b0000000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
        .pcen(pcen), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, alucontrol, pcsrc, pcen, illegal_op};

    function automatic logic [2:0] fdec(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic is_ill(input logic [5:0] o);
        case (o)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b0;
            6'b000101: return ~BNE_EN;
            default:   return 1'b1;
        endcase
    endfunction

    // Field order: iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca | alusrcb | alucontrol | pcsrc | pcen | illegal_op
    function automatic logic [15:0] expv(input tst_e s, input logic [5:0] o,
                                         input logic [5:0] f, input logic z);
        case (s)
            T_F:         return {7'b0010000, 2'b01, 3'b010, 2'b00, 1'b1, 1'b0};
            T_D:         return {7'b0000000, 2'b11, 3'b010, 2'b00, 1'b0, is_ill(o)};
            T_MA, T_AIE: return {7'b0000001, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
            T_MR:        return {7'b1000000, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0};
            T_MWB:       return {7'b0000110, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0};
            T_MW:        return {7'b1100000, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0};
            T_EX:        return {7'b0000001, 2'b00, fdec(f), 2'b00, 1'b0, 1'b0};
            T_AWB:       return {7'b0001010, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0};
            T_BQ:        return {7'b0000001, 2'b00, 3'b110, 2'b01,
                                 (o == 6'b000101) ? ~z : z, 1'b0};
            T_AIW:       return {7'b0000010, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0};
            T_JP:        return {7'b0000000, 2'b00, 3'b010, 2'b10, 1'b1, 1'b0};
            default:     return 16'h0000;
        endcase
    endfunction

    task automatic push(input logic [15:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_one();
        exp_t e;
        e = sb.pop_front();
        compared++;
        assert (obs === e.v) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
        end
    endtask

    // Queue the expected state walk for one instruction and check it cycle by cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input string name);
        tst_e seq[$];
        seq = '{T_F, T_D};
        case (o)
            6'b100011: seq = '{T_F, T_D, T_MA, T_MR, T_MWB};
            6'b101011: seq = '{T_F, T_D, T_MA, T_MW};
            6'b000000: seq = '{T_F, T_D, T_EX, T_AWB};
            6'b000100: seq = '{T_F, T_D, T_BQ};
            6'b001000: seq = '{T_F, T_D, T_AIE, T_AIW};
            6'b000010: seq = '{T_F, T_D, T_JP};
            6'b000101: if (BNE_EN) seq = '{T_F, T_D, T_BQ}; else seq = '{T_F, T_D};
            default:   seq = '{T_F, T_D};
        endcase
        op = o; funct = f; zero = z;
        foreach (seq[i]) push(expv(seq[i], o, f, z), $sformatf("%s_c%0d", name, i + 1));
        while (sb.size() > 0) begin
            #1;
            check_one();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
        @(posedge clk); #1;
        push(V_RESET, "reset_c1"); check_one();
        @(posedge clk); #1;
        push(V_RESET, "reset_c2"); check_one();
        reset = 1'b0;

        run_instr(6'b100011, 6'b000000, 1'b0, "lw");
        run_instr(6'b101011, 6'b000000, 1'b0, "sw");
        run_instr(6'b000000, 6'b101010, 1'b0, "r_slt");
        run_instr(6'b000000, 6'b100000, 1'b0, "r_add");
        run_instr(6'b000000, 6'b100010, 1'b0, "r_sub");
        run_instr(6'b000000, 6'b100100, 1'b0, "r_and");
        run_instr(6'b000000, 6'b100101, 1'b0, "r_or");
        run_instr(6'b000000, 6'b100111, 1'b0, "r_badfn");
        run_instr(6'b000100, 6'b000000, 1'b1, "beq_z1");
        run_instr(6'b000100, 6'b000000, 1'b0, "beq_z0");
        run_instr(6'b000101, 6'b000000, 1'b0, "bne_z0");
        run_instr(6'b001000, 6'b000000, 1'b0, "addi");
        run_instr(6'b000010, 6'b000000, 1'b0, "j");
        run_instr(6'b111111, 6'b000000, 1'b0, "illegal");

        // sw interrupted by reset in its MEMWR cycle
        op = 6'b101011; zero = 1'b0;
        push(expv(T_F,  op, funct, zero), "swrst_fetch");
        push(expv(T_D,  op, funct, zero), "swrst_decode");
        push(expv(T_MA, op, funct, zero), "swrst_memadr");
        for (int i = 0; i < 3; i++) begin
            #1;
            check_one();
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        push(V_RESET, "swrst_memwr_masked"); check_one();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        push(expv(T_F, op, funct, zero), "swrst_refetch"); check_one();

        run_instr(6'b000010, 6'b000000, 1'b0, "j_after_rst");
        #1;
        push(expv(T_F, op, funct, zero), "final_fetch"); check_one();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control unit for the planned multicycle MIPS core.
- Moore FSM sequences one shared memory, instruction register, register file, ALU and PC through fetch/decode/execute/memory/writeback phases.
- Emits all datapath select and write-enable signals from opcode, funct and ALU zero flag.
- Instantiated inside the multicycle top next to the datapath; same instruction subset as the single-cycle core (lw, sw, R-type add/sub/and/or/slt, beq, addi, j).

Parameters:
- OPW, 6, opcode field width
- FNW, 6, funct field width

Ports:
- clk  input  1  core clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; one clock, reset synchronous and active-high
- op  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0] from instruction register
- zero  input  1  ALU zero flag, valid in BEQ state
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  data memory write enable
- irwrite  output  1  instruction register load
- regdst  output  1  write register select: 0=rt, 1=rd
- memtoreg  output  1  writeback select: 0=ALUOut, 1=MDR
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A: 0=PC, 1=rs
- alusrcb  output  2  ALU B: 00=rt, 01=const 4, 10=signimm, 11=signimm<<2
- alucontrol  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- pcsrc  output  2  next PC: 00=ALUResult, 01=ALUOut, 10=jump target
- pcen  output  1  PC register enable
- illegal_op  output  1  one-cycle pulse in DECODE on unsupported opcode

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQ, ADDIEX, ADDIWB, JUMP. Encoding lives in the package.
- Reset: state forced to FETCH on the next edge. While reset is high, memwrite, irwrite, regwrite, pcen and illegal_op are forced 0. All other outputs take FETCH values. Reset mid-instruction abandons the instruction; no partial writes occur after the reset edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - lw (100011) or sw (101011) -> MEMADR
    - R-type (000000) -> EXECUTE
    - beq (000100) -> BEQ
    - addi (001000) -> ADDIEX
    - j (000010) -> JUMP
    - any other opcode -> FETCH with illegal_op=1
  - MEMADR -> MEMRD if lw, MEMWR if sw.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BEQ, ADDIWB, JUMP -> FETCH.
- Outputs per state. Unlisted outputs are 0; alucontrol is derived from aluop.
  - FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=add (branch target precompute).
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=add.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=funct.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - BEQ: alusrca=1, alusrcb=00, aluop=sub, pcsrc=01, branch=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero). Purely combinational from state and zero; zero sampled only in BEQ.
- ALU decode, aluop=funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - other funct -> 010; the instruction still completes; no illegal_op.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

Optional Feature:
- MULTICYCLE_BNE_EN defined:
  - bne (000101) in DECODE -> BEQ state with internal branch_ne flag registered at DECODE.
  - pcen additionally asserted when branch & branch_ne & ~zero.
- Undefined: opcode 000101 is illegal; goes DECODE -> FETCH with illegal_op=1.

Decomposition:
- Package mips_mc_pkg holds:
  - state type and encoding
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE
  - funct constants
  - aluop type: add, sub, funct
  - alucontrol constants
- One sub-module, mc_aludec: combinational aluop + funct -> alucontrol.
- FSM and output logic stay in multicycle_ctrl.

Test Plan:
- reset high 2 cycles, then low -> during reset pcen=irwrite=regwrite=memwrite=0. First cycle after release: FETCH, irwrite=1, pcen=1, alusrcb=01.
- op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. Cycle 4 iord=1. Cycle 5 regwrite=1, memtoreg=1, regdst=0.
- op=101011 -> cycle 4 memwrite=1, iord=1. regwrite never asserted. Back in FETCH at cycle 5.
- op=000000, funct=101010 -> EXECUTE alucontrol=111, alusrca=1, alusrcb=00. ALUWB regwrite=1, regdst=1.
- op=000100 with zero=1 -> BEQ pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0 -> pcen=0. Repeat with op=000101 -> illegal_op=1 without MULTICYCLE_BNE_EN; pcen=1 at zero=0 with it.
- op=000010 -> JUMP pcsrc=10, pcen=1. Separately, reset asserted during MEMWR cycle -> memwrite=0 that cycle, FETCH next cycle.
